// File: rtl/microcode_sequencer_if.sv
// Bus bundle for the microcode sequencer: decode-side inputs,
// control-store write port and the registered control-word outputs.
interface microcode_sequencer_if #(
    parameter int CTRL_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int OPC_WIDTH  = 4
);
    localparam int W = CTRL_WIDTH + 3 + ADDR_WIDTH;

    logic                  start;
    logic                  stall;
    logic [OPC_WIDTH-1:0]  opcode;
    logic                  zflag;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [W-1:0]          wr_data;
    logic [W-1:0]          cs;
    logic [ADDR_WIDTH-1:0] upc;
    logic                  busy;
    logic                  stk_err;

    modport master (
        output start, stall, opcode, zflag, wr_en, wr_addr, wr_data,
        input  cs, upc, busy, stk_err
    );

    modport slave (
        input  start, stall, opcode, zflag, wr_en, wr_addr, wr_data,
        output cs, upc, busy, stk_err
    );
endinterface

// File: rtl/microcode_sequencer.sv
// Microprogram sequencer: writable control store, micro-PC, return
// stack and zero-penalty next-address selection from the current word.
module microcode_sequencer #(
    parameter int CTRL_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 5,
    parameter int OPC_WIDTH     = 4,
    parameter int DISPATCH_BASE = 2,
    parameter int STACK_DEPTH   = 4
) (
    input  logic clk,
    input  logic rst,
    microcode_sequencer_if.slave bus
);
    localparam int W     = CTRL_WIDTH + 3 + ADDR_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int SPW   = $clog2(STACK_DEPTH + 1);
    localparam int IW    = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [2:0] M_NEXT = 3'b000;
    localparam logic [2:0] M_JUMP = 3'b001;
    localparam logic [2:0] M_DISP = 3'b010;
    localparam logic [2:0] M_BRZ  = 3'b011;
    localparam logic [2:0] M_BRNZ = 3'b100;
    localparam logic [2:0] M_CALL = 3'b101;
    localparam logic [2:0] M_RET  = 3'b110;
    localparam logic [2:0] M_HALT = 3'b111;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                r_state, w_state_nxt;
    logic [W-1:0]          r_mem [0:DEPTH-1];
    logic [ADDR_WIDTH-1:0] r_stk [0:(2**IW)-1];
    logic [SPW-1:0]        r_sp;
    logic [ADDR_WIDTH-1:0] r_upc;
    logic [W-1:0]          r_cs;
    logic                  r_err;

    logic [OPC_WIDTH-1:0]  w_opc;
    logic [2:0]            w_mode;
    logic [ADDR_WIDTH-1:0] w_na, w_inc, w_disp, w_nxt;
    logic [IW-1:0]         w_top, w_wptr;
    logic                  w_push, w_pop, w_serr, w_halt;
    logic                  w_adv, w_launch;

    assign w_opc    = bus.opcode;
    assign w_mode   = r_cs[ADDR_WIDTH+2:ADDR_WIDTH];
    assign w_na     = r_cs[ADDR_WIDTH-1:0];
    assign w_inc    = r_upc + ADDR_WIDTH'(1);
    assign w_disp   = ADDR_WIDTH'(DISPATCH_BASE) + ADDR_WIDTH'(w_opc);
    assign w_top    = IW'(r_sp - SPW'(1));
    assign w_wptr   = IW'(r_sp);
    assign w_adv    = (r_state == S_RUN) && !bus.stall;
    assign w_launch = (r_state == S_IDLE) && bus.start;

    // Next micro-address and stack side effects from the current word
    always_comb begin
        w_nxt  = w_inc;
        w_push = 1'b0;
        w_pop  = 1'b0;
        w_serr = 1'b0;
        w_halt = 1'b0;
        case (w_mode)
            M_NEXT: w_nxt = w_inc;
            M_JUMP: w_nxt = w_na;
            M_DISP: w_nxt = w_disp;
            M_BRZ:  w_nxt = bus.zflag ? w_na : w_inc;
            M_BRNZ: w_nxt = bus.zflag ? w_inc : w_na;
            M_CALL: begin
                w_nxt = w_na;
                if (r_sp == SPW'(STACK_DEPTH)) w_serr = 1'b1;
                else                           w_push = 1'b1;
            end
            M_RET: begin
                if (r_sp == '0) begin
                    w_nxt  = '0;
                    w_serr = 1'b1;
                end else begin
                    w_nxt = r_stk[w_top];
                    w_pop = 1'b1;
                end
            end
            M_HALT: w_halt = 1'b1;
            default: w_nxt = w_inc;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM next state: start launches, a consumed HALT word stops
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
            S_RUN:   if (w_adv && w_halt) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus.busy    = (r_state == S_RUN);
        bus.cs      = r_cs;
        bus.upc     = r_upc;
        bus.stk_err = r_err;
    end

    // Micro-PC, control word, stack pointer and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_upc <= '0;
            r_cs  <= '0;
            r_sp  <= '0;
            r_err <= 1'b0;
        end else if (w_launch) begin
            r_upc <= '0;
            r_cs  <= r_mem[0];
        end else if (w_adv) begin
            if (w_halt) begin
                r_cs <= '0;
            end else begin
                r_upc <= w_nxt;
                r_cs  <= r_mem[w_nxt];
            end
            if (w_push) r_sp <= r_sp + SPW'(1);
            if (w_pop)  r_sp <= r_sp - SPW'(1);
            if (w_serr) r_err <= 1'b1;
        end
    end

    // Return-address storage, written on a successful push
    always_ff @(posedge clk) begin
        if (w_adv && w_push) r_stk[w_wptr] <= w_inc;
    end

    // Control store write port; reads above see the pre-write word
    always_ff @(posedge clk) begin
        if (bus.wr_en) r_mem[bus.wr_addr] <= bus.wr_data;
    end
endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: directed program checks with literal
// expectations plus randomized programs against a behavioural model.
module tb_microcode_sequencer;
    localparam int CW = 32;
    localparam int AW = 5;
    localparam int OW = 5;
    localparam int DB = 2;
    localparam int SD = 4;
    localparam int W  = CW + 3 + AW;
    localparam int ND = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   cmp_en  = 1'b0;

    microcode_sequencer_if #(.CTRL_WIDTH(CW), .ADDR_WIDTH(AW), .OPC_WIDTH(OW)) bus ();

    microcode_sequencer #(
        .CTRL_WIDTH(CW), .ADDR_WIDTH(AW), .OPC_WIDTH(OW),
        .DISPATCH_BASE(DB), .STACK_DEPTH(SD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [W-1:0] m_mem [ND];
    bit           m_run;
    int           m_upc;
    logic [W-1:0] m_cs;
    bit           m_err;
    int           m_stk[$];

    function automatic logic [W-1:0] mk(int md, int na, int ctrl);
        return {CW'(ctrl), 3'(md), AW'(na)};
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_run = 0;
        m_upc = 0;
        m_cs  = '0;
        m_err = 0;
        m_stk.delete();
    endtask

    task automatic model_step();
        int md, na, nxt;
        if (!m_run) begin
            if (bus.start) begin
                m_run = 1;
                m_upc = 0;
                m_cs  = m_mem[0];
            end
        end else if (!bus.stall) begin
            md  = int'(m_cs[AW+2:AW]);
            na  = int'(m_cs[AW-1:0]);
            nxt = (m_upc + 1) % ND;
            if (md == 1) nxt = na;
            if (md == 2) nxt = (DB + int'(bus.opcode)) % ND;
            if (md == 3 && bus.zflag) nxt = na;
            if (md == 4 && !bus.zflag) nxt = na;
            if (md == 5) begin
                if (m_stk.size() == SD) m_err = 1;
                else m_stk.push_back((m_upc + 1) % ND);
                nxt = na;
            end
            if (md == 6) begin
                if (m_stk.size() == 0) begin
                    nxt = 0;
                    m_err = 1;
                end else begin
                    nxt = m_stk.pop_back();
                end
            end
            if (md == 7) begin
                m_run = 0;
                m_cs  = '0;
            end else begin
                m_upc = nxt;
                m_cs  = m_mem[nxt];
            end
        end
        if (bus.wr_en) m_mem[bus.wr_addr] = bus.wr_data;
    endtask

    always @(posedge rst) m_reset();

    always @(posedge clk) if (!rst) model_step();

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_busy", 64'(bus.busy), 64'(m_run));
            chk("m_upc", 64'(bus.upc), 64'(m_upc));
            chk("m_cs", 64'(bus.cs), 64'(m_cs));
            chk("m_stkerr", 64'(bus.stk_err), 64'(m_err));
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wr(int a, logic [W-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(a);
        bus.wr_data = d;
        cyc();
        bus.wr_en = 1'b0;
    endtask

    task automatic clear_mem();
        for (int a = 0; a < ND; a++) wr(a, mk(7, 0, a));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic go();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic run_to_idle();
        for (int k = 0; k < 100 && bus.busy; k++) cyc();
        chk("idle_bound", 64'(bus.busy), 64'd0);
    endtask

    task automatic lit_upc(string nm, int e);
        chk(nm, 64'(bus.upc), 64'(e));
    endtask

    int seq5[10] = '{0, 20, 22, 24, 26, 28, 25, 23, 21, 1};

    initial begin
        bus.start = 0; bus.stall = 0; bus.opcode = '0; bus.zflag = 0;
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
        for (int a = 0; a < ND; a++) m_mem[a] = '0;
        m_reset();
        repeat (3) cyc();
        rst = 1'b0;
        cmp_en = 1'b1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_cs", 64'(bus.cs), 64'd0);
        chk("rst_upc", 64'(bus.upc), 64'd0);
        chk("rst_err", 64'(bus.stk_err), 64'd0);

        // NEXT, JUMP, HALT
        clear_mem();
        wr(0, mk(0, 0, 'h100)); wr(1, mk(1, 5, 'h101)); wr(5, mk(7, 0, 'h105));
        go();
        lit_upc("seq0", 0);
        chk("seq0_cs", 64'(bus.cs), 64'(mk(0, 0, 'h100)));
        chk("seq0_busy", 64'(bus.busy), 64'd1);
        cyc(); lit_upc("seq1", 1);
        cyc(); lit_upc("seq5", 5);
        cyc();
        chk("halt_busy", 64'(bus.busy), 64'd0);
        chk("halt_cs", 64'(bus.cs), 64'd0);
        chk("halt_upc", 64'(bus.upc), 64'd5);

        // DISPATCH, including wrap
        clear_mem();
        wr(0, mk(2, 0, 0));
        bus.opcode = OW'(3);
        go(); cyc(); lit_upc("disp3", 5);
        run_to_idle();
        bus.opcode = OW'(31);
        go(); cyc(); lit_upc("disp31_wrap", 1);
        run_to_idle();

        // BRZ / BRNZ both ways
        for (int c = 0; c < 4; c++) begin
            int md, e;
            md = (c < 2) ? 3 : 4;
            bus.zflag = c[0];
            e = (md == 3) ? (c[0] ? 9 : 5) : (c[0] ? 5 : 9);
            clear_mem();
            wr(0, mk(1, 4, 0)); wr(4, mk(md, 9, 0));
            go(); cyc(); lit_upc("br_at4", 4);
            cyc(); lit_upc($sformatf("br_m%0d_z%0d", md, c[0]), e);
            run_to_idle();
        end
        bus.zflag = 0;

        // CALL / RET
        clear_mem();
        wr(0, mk(1, 2, 0)); wr(2, mk(5, 10, 0)); wr(10, mk(6, 0, 0));
        go(); lit_upc("call0", 0);
        cyc(); lit_upc("call2", 2);
        cyc(); lit_upc("call10", 10);
        cyc(); lit_upc("ret3", 3);
        chk("call_err", 64'(bus.stk_err), 64'd0);
        run_to_idle();

        // Five nested calls overflow a 4-deep stack
        clear_mem();
        wr(0, mk(5, 20, 0)); wr(20, mk(5, 22, 0)); wr(22, mk(5, 24, 0));
        wr(24, mk(5, 26, 0)); wr(26, mk(5, 28, 0)); wr(28, mk(6, 0, 0));
        wr(21, mk(6, 0, 0)); wr(23, mk(6, 0, 0)); wr(25, mk(6, 0, 0));
        wr(27, mk(6, 0, 0));
        go();
        for (int i = 0; i < 10; i++) begin
            lit_upc($sformatf("nest%0d", i), seq5[i]);
            if (i == 4) chk("nest_err_pre", 64'(bus.stk_err), 64'd0);
            if (i == 5) chk("nest_err", 64'(bus.stk_err), 64'd1);
            cyc();
        end
        chk("nest_done", 64'(bus.busy), 64'd0);
        do_reset();

        // RET on empty stack, then async reset mid-run
        clear_mem();
        wr(0, mk(1, 7, 0)); wr(7, mk(6, 0, 0));
        go(); lit_upc("empty0", 0);
        cyc(); lit_upc("empty7", 7);
        cyc(); lit_upc("empty_ret", 0);
        chk("empty_err", 64'(bus.stk_err), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_cs", 64'(bus.cs), 64'd0);
        chk("arst_upc", 64'(bus.upc), 64'd0);
        chk("arst_err", 64'(bus.stk_err), 64'd0);
        cyc();
        rst = 1'b0;
        go();
        lit_upc("restart_upc", 0);
        chk("restart_busy", 64'(bus.busy), 64'd1);
        chk("restart_cs", 64'(bus.cs), 64'(mk(1, 7, 0)));
        do_reset();

        // Stall with a write to the word about to be fetched
        clear_mem();
        wr(0, mk(0, 0, 'h11)); wr(1, mk(0, 0, 'h22)); wr(2, mk(0, 0, 'h33));
        go(); lit_upc("st0", 0);
        cyc(); lit_upc("st1", 1);
        bus.stall = 1'b1;
        bus.wr_en = 1'b1; bus.wr_addr = AW'(2); bus.wr_data = mk(1, 9, 'hABCD);
        for (int i = 0; i < 3; i++) begin
            cyc();
            bus.wr_en = 1'b0;
            lit_upc("st_hold", 1);
            chk("st_hold_cs", 64'(bus.cs), 64'(mk(0, 0, 'h22)));
        end
        bus.stall = 1'b0;
        cyc(); lit_upc("st_rel", 2);
        chk("st_newword", 64'(bus.cs), 64'(mk(1, 9, 'hABCD)));
        cyc(); lit_upc("st_jump", 9);
        run_to_idle();

        // Randomized programs against the model
        for (int a = 0; a < ND; a++) wr(a, mk($urandom_range(0, 7), $urandom, $urandom));
        for (int i = 0; i < 4000; i++) begin
            cyc();
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                cyc();
                rst = 1'b0;
            end
            bus.start  = ($urandom_range(0, 9) < 3);
            bus.stall  = ($urandom_range(0, 9) < 2);
            bus.opcode = OW'($urandom);
            bus.zflag  = 1'($urandom);
            bus.wr_en  = ($urandom_range(0, 9) == 0);
            bus.wr_addr = AW'($urandom);
            bus.wr_data = mk($urandom_range(0, 7), $urandom, $urandom);
        end
        bus.wr_en = 1'b0;
        cyc();
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/microcode_sequencer.md
# microcode_sequencer

Parametrised microprogram sequencer for the control unit: a writable control store of `2**ADDR_WIDTH` words plus a micro-PC, return stack and next-address logic. Each cycle it emits one registered control word and selects the next micro-address. The selection is sequential, jump, opcode dispatch, conditional branch, call/return or halt. The sequencer sits between instruction decode (opcode, flags) and the datapath control lines, and replaces the fixed ROM-plus-external-counter arrangement.

## Interface
- CTRL_WIDTH, 32, datapath control bits per word
- ADDR_WIDTH, 5, micro-address width; store depth is `2**ADDR_WIDTH`
- OPC_WIDTH, 4, opcode width used for dispatch
- DISPATCH_BASE, 2, micro-address of opcode 0's first microinstruction
- STACK_DEPTH, 4, return stack entries (≥1)
- Word layout, W = CTRL_WIDTH+3+ADDR_WIDTH: {ctrl[CTRL_WIDTH-1:0], mode[2:0], next_addr[ADDR_WIDTH-1:0]}
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin execution at address 0 (sampled in IDLE only)
- stall  in  1  hold upc, cs, stack (RUN only)
- opcode  in  OPC_WIDTH  instruction opcode for DISPATCH
- zflag  in  1  branch condition
- wr_en  in  1  control-store write strobe
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  W  write data
- cs  out  W  current control word (registered)
- upc  out  ADDR_WIDTH  address of word on cs
- busy  out  1  high in RUN
- stk_err  out  1  sticky stack overflow/underflow flag

## Operation
- Reset (async): state IDLE, upc=0, cs=0, busy=0, stk_err=0, stack pointer=0 (empty). Store contents are not reset.
- IDLE: cs=0. If start=1, then upc←0, cs←store[0], state←RUN.
- RUN: if stall=1, hold everything. Otherwise compute nxt from the current cs.mode, then upc←nxt and cs←store[nxt].
- Mode 000 NEXT: nxt=upc+1.
- Mode 001 JUMP: nxt=next_addr.
- Mode 010 DISPATCH: nxt=DISPATCH_BASE+opcode.
- Mode 011 BRZ: nxt = zflag ? next_addr : upc+1.
- Mode 100 BRNZ: nxt = zflag ? upc+1 : next_addr.
- Mode 101 CALL: push upc+1, nxt=next_addr. If the stack is full, the push is dropped, the jump is still taken, and stk_err←1.
- Mode 110 RET: pop, nxt=popped value. If the stack is empty, nxt=0 and stk_err←1.
- Mode 111 HALT: state←IDLE, cs←0, upc holds.
- Address arithmetic is modulo `2**ADDR_WIDTH`: upc+1 wraps from max to 0, and DISPATCH_BASE+opcode wraps.
- stk_err clears only on rst.
- Writes happen in any state, including while stalled. A write to the address being read in the same cycle returns the old data to cs; the new data is visible from the next read.
- start in RUN and stall in IDLE are ignored.

## Timing
- Start latency: start sampled high at edge N gives cs=store[0] and busy=1 after edge N.
- One microinstruction per non-stalled cycle. Next-address selection uses the current cs, so a branch has zero penalty.
- zflag and opcode are sampled at the same edge that consumes the word carrying BRZ/BRNZ/DISPATCH.
- HALT word visible in cycle k gives cs=0 and busy=0 after edge k; a restart is possible from the following edge.
- stall held high for any number of cycles leaves cs, upc and the stack unchanged. Release resumes on the next edge.
- Asserting rst mid-program returns to IDLE immediately (asynchronous), with outputs at reset values and the stack emptied.

## Test plan
- Load store[0]=NEXT, store[1]=JUMP→5, store[5]=HALT; pulse start → upc sequence 0,1,5, then busy=0 and cs=0 on the cycle after 5.
- DISPATCH at store[0] with opcode=3, DISPATCH_BASE=2 → upc=5; opcode=31 with OPC_WIDTH=5, ADDR_WIDTH=5 → upc wraps to 1.
- BRZ→9 at addr 4: zflag=1 → upc=9; zflag=0 → upc=5. BRNZ gives the inverse outcome.
- CALL→10 at addr 2, RET at 10 → upc 2,10,3. Five nested CALLs with STACK_DEPTH=4 → stk_err=1 and the fifth return goes wrong as specified. RET on empty stack → upc=0 and stk_err=1.
- stall held 3 cycles mid-program → cs/upc frozen 3 cycles, then sequence resumes. Write to current+1 address while stalled → the new word is fetched after release.
- rst asserted asynchronously between edges during RUN → busy, cs, upc and stk_err all 0 before the next edge; start afterwards restarts at address 0.
